// File: rtl/gamedefs_pkg.sv
// Shared drawing-pipeline definitions: screen geometry, color width and the pixel records
// passed between the draw datapath, the plot stage and the VGA adapter.
package gamedefs_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOR_W  = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam logic [COLOR_W-1:0] BLACK = 3'b000;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // One stage of the coordinate delay line that waits out the color ROM latency.
    typedef struct packed {
        logic           vld;
        logic           fe;
        logic           spr;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } dline_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous pixel FIFO with first-word-fall-through head. A write while full is dropped
// unless a read happens in the same cycle, so stored contents are never corrupted.
module plot_fifo
    import gamedefs_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  pixel_t      din,
    output pixel_t      dout,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    pixel_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    always_comb begin
        rd_en    = rd && (count_q != '0);
        wr_en    = wr && ((count_q != FULL_CNT) || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;

endmodule

// File: rtl/plot_stage.sv
// Plot stage: aligns draw-FSM pixels with the color ROM latency, clips off-screen pixels,
// buffers them for the VGA adapter and paces the FSM. Define PLOT_STAGE_TRANSPARENCY_EN to drop KEY-colored sprite pixels.
module plot_stage
    import gamedefs_pkg::*;
#(
    parameter int                 ROM_LAT = 1,
    parameter int                 DEPTH   = 8,
    parameter int                 SLACK   = 2,
    parameter int                 X_MAX   = SCREEN_W,
    parameter int                 Y_MAX   = SCREEN_H,
    parameter logic [COLOR_W-1:0] KEY     = BLACK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixValid,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic               spriteMode,
    input  logic [COLOR_W-1:0] color,
    input  logic               frameEnd,
    input  logic               vgaReady,
    output logic [X_W-1:0]     vgaX,
    output logic [Y_W-1:0]     vgaY,
    output logic [COLOR_W-1:0] vgaColor,
    output logic               plot,
    output logic               stall,
    output logic               drawDone,
    output logic [14:0]        pixelCount
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          STALL_OCC = DEPTH - SLACK;
    localparam logic [AW:0] STALL_AT  = STALL_OCC[AW:0];
    localparam logic [X_W:0] X_LIM    = X_MAX[X_W:0];
    localparam logic [Y_W:0] Y_LIM    = Y_MAX[Y_W:0];

    // Pixels already in the delay line when stall rises must still fit in the FIFO.
    if (SLACK < ROM_LAT) begin : g_slack_chk
        $error("plot_stage: SLACK must be >= ROM_LAT");
    end
    if (SLACK >= DEPTH) begin : g_slack_depth_chk
        $error("plot_stage: SLACK must be < DEPTH");
    end
    if (ROM_LAT < 1) begin : g_lat_chk
        $error("plot_stage: ROM_LAT must be >= 1");
    end
    if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_depth_chk
        $error("plot_stage: DEPTH must be a power of two >= 4");
    end

    dline_t [ROM_LAT-1:0] dl_q, dl_d;
    dline_t      tail;
    logic        pipe_busy, in_bounds, accept;
    pixel_t      fifo_din, fifo_dout, head_q, head_d, shown;
    logic        fifo_empty, unused_full, xfer, done;
    logic [AW:0] fifo_count;
    logic        pending_q, pending_d;
    logic [14:0] pix_cnt_q, pix_cnt_d;

`ifndef PLOT_STAGE_TRANSPARENCY_EN
    logic unused_spr;
    assign unused_spr = ^{tail.spr, KEY};
`endif

    always_comb begin
        dl_d[0] = {pixValid, frameEnd, spriteMode, x, y};
        for (int i = 1; i < ROM_LAT; i++) dl_d[i] = dl_q[i-1];
        tail      = dl_q[ROM_LAT-1];
        pipe_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) pipe_busy = pipe_busy | dl_q[i].vld;

        in_bounds = tail.vld && ({1'b0, tail.x} < X_LIM) && ({1'b0, tail.y} < Y_LIM);
`ifdef PLOT_STAGE_TRANSPARENCY_EN
        accept = in_bounds && !(tail.spr && (color == KEY));
`else
        accept = in_bounds;
`endif
        fifo_din = {tail.x, tail.y, color};

        xfer   = !fifo_empty && vgaReady;
        head_d = xfer ? fifo_dout : head_q;
        shown  = fifo_empty ? head_q : fifo_dout;

        // A frameEnd landing while a frame is still pending folds into that one drawDone.
        done      = pending_q && !pipe_busy && fifo_empty;
        pending_d = pending_q ? !done : tail.fe;

        pix_cnt_d = (xfer && (pix_cnt_q != '1)) ? pix_cnt_q + 1'b1 : pix_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q      <= '0;
            head_q    <= '0;
            pending_q <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            dl_q      <= dl_d;
            head_q    <= head_d;
            pending_q <= pending_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    plot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (accept),
        .rd    (xfer),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (unused_full),
        .count (fifo_count)
    );

    assign vgaX       = shown.x;
    assign vgaY       = shown.y;
    assign vgaColor   = shown.color;
    assign plot       = !fifo_empty;
    assign stall      = (fifo_count >= STALL_AT);
    assign drawDone   = done;
    assign pixelCount = pix_cnt_q;

endmodule

// File: tb/tb_plot_stage.sv
// Directed bench for plot_stage at default parameters (ROM_LAT=1, DEPTH=8, SLACK=2);
// expected values are hand-derived per test below.
module tb_plot_stage;
    import gamedefs_pkg::*;

`ifdef PLOT_STAGE_TRANSPARENCY_EN
    localparam int T3_SPR_CNT = 1;
    localparam int T3_SPR_C0  = 5;
`else
    localparam int T3_SPR_CNT = 3;
    localparam int T3_SPR_C0  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, pixValid, spriteMode, frameEnd, vgaReady;
    logic [7:0]  x, vgaX;
    logic [6:0]  y, vgaY;
    logic [2:0]  color, vgaColor, nxt_color;
    logic        plot, stall, drawDone;
    logic [14:0] pixelCount;

    int     n_chk = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    pixel_t got[$];

    always #5 clk = ~clk;

    plot_stage dut (
        .clk        (clk),
        .reset      (reset),
        .pixValid   (pixValid),
        .x          (x),
        .y          (y),
        .spriteMode (spriteMode),
        .color      (color),
        .frameEnd   (frameEnd),
        .vgaReady   (vgaReady),
        .vgaX       (vgaX),
        .vgaY       (vgaY),
        .vgaColor   (vgaColor),
        .plot       (plot),
        .stall      (stall),
        .drawDone   (drawDone),
        .pixelCount (pixelCount)
    );

    // Adapter-side monitor: records every transfer and every drawDone pulse.
    always @(posedge clk) begin
        if (!reset && plot && vgaReady) got.push_back({vgaX, vgaY, vgaColor});
        if (drawDone) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one cycle; the color of last cycle's pixel is presented now (ROM_LAT=1).
    task automatic tick();
        @(posedge clk);
        #1;
        color      = nxt_color;
        nxt_color  = '0;
        pixValid   = 1'b0;
        frameEnd   = 1'b0;
        spriteMode = 1'b0;
        x          = '0;
        y          = '0;
    endtask

    task automatic pix(input int xi, input int yi, input logic spr, input logic [2:0] c);
        pixValid   = 1'b1;
        x          = 8'(xi);
        y          = 7'(yi);
        spriteMode = spr;
        nxt_color  = c;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        vgaReady = 1'b0;
        idle(2);
        reset    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, d, sent, first_stall, sent_at_stall;
        reset = 1'b1; pixValid = 1'b0; spriteMode = 1'b0; frameEnd = 1'b0; vgaReady = 1'b0;
        x = '0; y = '0; color = '0; nxt_color = '0;

        // Reset state
        do_reset();
        check("rst_plot", plot, 0);
        check("rst_stall", stall, 0);
        check("rst_done", drawDone, 0);
        check("rst_count", pixelCount, 0);
        check("rst_vgax", vgaX, 0);
        check("rst_color", vgaColor, 0);

        // Test 1: 10-pixel line, latency and drawDone
        b = got.size(); d = done_cnt; vgaReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) check("t1_plot_lat1", plot, 0);
            if (i == 2) begin
                check("t1_plot_lat2", plot, 1);
                check("t1_head_x", vgaX, 0);
            end
            pix(i, 5, 1'b0, 3'(i));
        end
        tick(); frameEnd = 1'b1;
        idle(12);
        check("t1_xfers", got.size() - b, 10);
        for (int i = 0; i < 10; i++) begin
            check("t1_x", got[b+i].x, i);
            check("t1_color", got[b+i].color, i % 8);
        end
        check("t1_y", got[b].y, 5);
        check("t1_count", pixelCount, 10);
        check("t1_done", done_cnt - d, 1);
        check("t1_idle_plot", plot, 0);
        check("t1_hold_x", vgaX, 9);
        check("t1_hold_color", vgaColor, 1);

        // Test 2: clipping at the screen edges
        do_reset(); vgaReady = 1'b1; b = got.size(); d = done_cnt;
        tick(); pix(159, 119, 1'b0, 3'd5);
        tick(); pix(160, 0, 1'b0, 3'd1);
        tick(); pix(0, 120, 1'b0, 3'd2);
        tick(); frameEnd = 1'b1;
        idle(8);
        check("t2_xfers", got.size() - b, 1);
        check("t2_x", got[b].x, 159);
        check("t2_y", got[b].y, 119);
        check("t2_color", got[b].color, 5);
        check("t2_count", pixelCount, 1);
        check("t2_done", done_cnt - d, 1);

        // Test 3: sprite transparency (m=0 sprite, m=1 background)
        for (int m = 0; m < 2; m++) begin
            do_reset(); vgaReady = 1'b1; b = got.size();
            tick(); pix(1, 1, m == 0, 3'b000);
            tick(); pix(2, 1, m == 0, 3'b101);
            tick(); pix(3, 1, m == 0, 3'b000);
            idle(6);
            check("t3_xfers", got.size() - b, (m == 0) ? T3_SPR_CNT : 3);
            check("t3_count", pixelCount, (m == 0) ? T3_SPR_CNT : 3);
            check("t3_first_color", got[b].color, (m == 0) ? T3_SPR_C0 : 0);
        end

        // Test 4: backpressure with an FSM that honours stall
        do_reset(); b = got.size();
        sent = 0; first_stall = -1; sent_at_stall = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 20) vgaReady = 1'b1;
            if (k == 19) begin
                check("t4_hold_stall", stall, 1);
                check("t4_hold_noxfer", got.size() - b, 0);
            end
            if (stall && first_stall < 0) begin
                first_stall   = k;
                sent_at_stall = sent;
            end
            if (!stall && sent < 12) begin
                pix(20 + sent, 7, 1'b0, 3'(sent));
                sent++;
            end
        end
        idle(5);
        check("t4_stall_cycle", first_stall, 7);
        check("t4_sent_at_stall", sent_at_stall, 7);
        check("t4_sent", sent, 12);
        check("t4_xfers", got.size() - b, 12);
        for (int i = 0; i < 12; i++) check("t4_order", got[b+i].x, 20 + i);
        check("t4_count", pixelCount, 12);

        // Test 5: read+write while full, then a true overflow
        do_reset(); b = got.size();
        for (int k = 0; k < 14; k++) begin
            tick();
            vgaReady = (k == 9);
            if (k == 10) begin
                check("t5_full_stall", stall, 1);
                check("t5_head", vgaX, 41);
                check("t5_one_xfer", got.size() - b, 1);
            end
            if (k < 10) pix(40 + k, 9, 1'b0, 3'(k));
        end
        vgaReady = 1'b1;
        idle(12);
        check("t5_xfers", got.size() - b, 9);
        for (int i = 0; i < 9; i++) check("t5_order", got[b+i].x, 40 + i);
        check("t5_count", pixelCount, 9);

        // Test 6: reset with a frame in flight
        do_reset(); b = got.size(); d = done_cnt;
        for (int k = 0; k < 7; k++) begin
            tick();
            pix(60 + k, 3, 1'b0, 3'(k));
        end
        tick(); frameEnd = 1'b1;
        idle(2);
        vgaReady = 1'b1;
        idle(2);
        vgaReady = 1'b0;
        check("t6_pre_count", pixelCount, 2);
        check("t6_pre_plot", plot, 1);
        reset = 1'b1;
        tick();
        check("t6_plot", plot, 0);
        check("t6_count", pixelCount, 0);
        check("t6_done_now", drawDone, 0);
        check("t6_stall", stall, 0);
        reset = 1'b0; vgaReady = 1'b1;
        idle(10);
        check("t6_no_done", done_cnt - d, 0);
        check("t6_xfers", got.size() - b, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_stage.md
Name: plot_stage

Overview:
- Sits directly downstream of the drawing datapath (x, y, color outputs) and upstream of the VGA adapter write port.
- Delays the per-pixel write strobe and coordinates so they line up with the synchronous ROM read latency of the color path.
- Discards off-screen pixels and, optionally, transparent sprite pixels.
- Buffers accepted pixels in a small FIFO, drains them to the adapter under a ready handshake, and tells the draw FSM when to pause counting.

Parameters:
- ROM_LAT, 1, cycles from address/coordinate presentation to valid color.
- DEPTH, 8, FIFO entries (power of two, minimum 4).
- SLACK, 2, free entries at or below which stall asserts.
- X_MAX, 160, screen width; pixels with x >= X_MAX are dropped.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are dropped.
- KEY, 3'b000, transparent color code in sprite mode.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pixValid  in  1  the FSM asserts this in the same cycle it presents coordinates/address.
- x  in  8  pixel x coordinate.
- y  in  7  pixel y coordinate.
- spriteMode  in  1  high when the current pixel comes from a sprite ROM; sampled with pixValid.
- color  in  3  ROM color, valid ROM_LAT cycles after pixValid.
- frameEnd  in  1  single-cycle pulse from the FSM after the last pixValid of a screen or sprite.
- vgaReady  in  1  the adapter accepts a pixel this cycle.
- vgaX  out  8  FIFO head x.
- vgaY  out  7  FIFO head y.
- vgaColor  out  3  FIFO head color.
- plot  out  1  FIFO non-empty; the pixel transfers when plot && vgaReady.
- stall  out  1  free entries <= SLACK; the FSM must hold its counters while this is high.
- drawDone  out  1  one-cycle pulse when a frame has fully drained.
- pixelCount  out  15  pixels written since reset; saturates at 32767.

Behaviour:
- Reset: all delay-line valids 0; FIFO empty; plot=0, stall=0, drawDone=0; pixelCount=0; vgaX/vgaY/vgaColor=0; pending-frame flag cleared.
- Delay line:
  - pixValid, x, y and spriteMode pass through a ROM_LAT-stage shift register.
  - At the last stage they are paired with the color present that cycle.
- Filter:
  - A candidate is accepted if x < X_MAX and y < Y_MAX, and (when the optional feature is enabled) not (spriteMode && color == KEY).
  - Rejected candidates are silently dropped and are not counted.
- FIFO:
  - Write on accept; read on plot && vgaReady.
  - Simultaneous read and write when full is legal; occupancy is unchanged.
  - A write when full and not reading is an overflow: the pixel is dropped and the FIFO is not corrupted.
  - Because the delay line holds up to ROM_LAT in-flight pixels after stall rises, SLACK >= ROM_LAT is a parameter legality rule; SLACK < ROM_LAT is a compile-time error.
- Outputs: vgaX/vgaY/vgaColor always show the FIFO head. They hold their last value when empty; plot=0 then.
- stall is combinational from the registered occupancy. Zero-latency assertion is acceptable.
- Frame tracking:
  - frameEnd sets the pending flag ROM_LAT cycles later, i.e. it is aligned with the delay line.
  - drawDone pulses in the first cycle where pending=1, the delay line is empty and the FIFO is empty; the flag then clears.
  - A frameEnd arriving while already pending keeps a single pending flag, giving a single drawDone.
- pixelCount increments on each transfer (plot && vgaReady) and saturates at 32767.
- Reset mid-frame flushes the FIFO and delay line. No drawDone is produced for the aborted frame.

Optional Feature:
- Macro: PLOT_STAGE_TRANSPARENCY_EN.
- Defined: sprite pixels whose color equals KEY are dropped, so background shows through.
- Undefined: KEY is ignored and every in-bounds pixel is written; spriteMode affects nothing.

Decomposition:
- Shared package gamedefs_pkg holds SCREEN_W=160, SCREEN_H=120, COLOR_W=3, X_W=8, Y_W=7, BLACK=3'b000, and the pixel struct {x, y, color}.
- One sub-module: plot_fifo, a synchronous FIFO with parameter DEPTH. Its ports are wr, rd, din, dout, empty, full and count.

Test Plan:
1. Reset, then 10 consecutive pixValid at x=0..9, y=5, vgaReady=1, ROM_LAT=1 → plot first asserts 2 cycles after the first pixValid; 10 transfers occur; pixelCount=10; drawDone pulses once after frameEnd.
2. Pixels at x=159,y=119 and x=160,y=0 and x=0,y=120 → only (159,119) is plotted; pixelCount=1.
3. Macro defined, spriteMode=1, colors 000,101,000 → only 101 is written; with spriteMode=0 all three are written. Macro undefined → all three are written in both cases.
4. vgaReady=0 with continuous pixValid, DEPTH=8, SLACK=2 → stall rises at occupancy 6; the FSM model stops; no overflow; all pixels emerge in order once vgaReady=1.
5. Full FIFO with vgaReady=1 and an accept in the same cycle → occupancy stays 8; order is preserved.
6. reset asserted with 5 pixels buffered → next cycle plot=0, pixelCount=0, and no drawDone.
